// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared opcodes, instruction field slices and scoreboard entry type
package hazard_pkg;

    localparam logic [5:0] OPC_RT = 6'b000000;
    localparam logic [5:0] OPC_LW = 6'b000011;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_unit_scoreboard.sv
// rtl/hazard_scoreboard_unit_scoreboard.sv - LOAD_LAT-deep shift register of in-flight load destinations
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift_i,
    input  sb_entry_t                din_i,
    output sb_entry_t [LOAD_LAT-1:0] entries_o
);

    sb_entry_t [LOAD_LAT-1:0] entries_q;
    sb_entry_t [LOAD_LAT-1:0] entries_d;

    always_comb begin
        entries_d = entries_q;
        for (int k = 1; k < LOAD_LAT; k++) begin
            entries_d[k] = entries_q[k-1];
        end
        entries_d[0] = din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q <= '0;
        end else if (shift_i) begin
            entries_q <= entries_d;
        end
    end

    assign entries_o = entries_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - load-use hazard detector; HAZARD_FLUSH_EN adds branch flush of IF/ID
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int WARMUP   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Inst,
    input  logic        mem_stall,
`ifdef HAZARD_FLUSH_EN
    input  logic        branch_taken,
    output logic        IFIDFlush,
`endif
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        NOP
);

    logic                     is_rt;
    logic                     is_lw;
    logic [4:0]               dst;
    logic [4:0]               rs;
    logic [4:0]               rt;
    logic                     conflict;
    logic                     warm;
    logic                     hazard;
    logic                     sb_shift;
    sb_entry_t                sb_din;
    sb_entry_t [LOAD_LAT-1:0] sb_entries;
    logic [3:0]               warm_cnt_q;
    logic [3:0]               warm_cnt_d;
    logic                     unused_inst_bits;

    assign is_rt = (Inst[OP_HI:OP_LO] == OPC_RT);
    assign is_lw = (Inst[OP_HI:OP_LO] == OPC_LW);
    assign rs    = Inst[RS_HI:RS_LO];
    assign rt    = Inst[RT_HI:RT_LO];
    assign dst   = is_rt ? Inst[RD_HI:RD_LO] : rt;
    assign unused_inst_bits = ^Inst[RD_LO-1:0];

    always_comb begin
        conflict = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (sb_entries[k].valid && (sb_entries[k].rd != 5'd0) &&
                ((sb_entries[k].rd == rs) || (is_rt && (sb_entries[k].rd == rt)))) begin
                conflict = 1'b1;
            end
        end
    end

    // Counter keeps running through mem_stall so warm-up is measured in wall cycles.
    assign warm       = (warm_cnt_q == 4'(WARMUP));
    assign warm_cnt_d = warm ? warm_cnt_q : warm_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt_q <= 4'd0;
        end else begin
            warm_cnt_q <= warm_cnt_d;
        end
    end

    assign hazard = conflict & warm & ~mem_stall & ~rst;

    always_comb begin
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        NOP          = 1'b0;
        sb_shift     = 1'b1;
        sb_din.valid = is_lw & (dst != 5'd0);
        sb_din.rd    = dst;
`ifdef HAZARD_FLUSH_EN
        IFIDFlush    = 1'b0;
`endif
        if (mem_stall) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            sb_shift  = 1'b0;
        end
`ifdef HAZARD_FLUSH_EN
        else if (branch_taken && !rst) begin
            // Flushed instruction never executes, so it must not register as a load.
            IFIDFlush = 1'b1;
            NOP       = 1'b1;
            sb_din    = '0;
        end
`endif
        else if (hazard) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            NOP       = 1'b1;
            sb_din    = '0;
        end
    end

    hazard_scoreboard #(
        .LOAD_LAT(LOAD_LAT)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .shift_i  (sb_shift),
        .din_i    (sb_din),
        .entries_o(sb_entries)
    );

endmodule
